// File: rtl/pll_clock_manager.sv
// rtl/pll_clock_manager.sv - PLL lock qualification, system reset sequencing and clock-enable tick channels
// Optional loss counter: define PLL_CLOCK_MANAGER_LOSS_COUNT_EN.
module pll_clock_manager #(
    parameter int NUM_CH             = 4,
    parameter int DIV_WIDTH          = 16,
    parameter int DIV_RESET          = 1,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                          clock_in,
    input  logic                          reset_n,
    input  logic                          pll_locked,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   div_value,
    input  logic [NUM_CH-1:0]             div_load,
    input  logic [NUM_CH-1:0]             ch_enable,
    output logic [NUM_CH-1:0]             tick,
    output logic                          sys_reset_n,
    output logic                          locked_stable,
    output logic [7:0]                    lock_lost_count
);

    localparam int CW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          stab_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic                   run_next;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Channels must see RUN on the same edge the state register enters it,
    // so that a d=1 channel ticks in the very first RUN cycle.
    assign run_next = lk_s && ((state == RUN) ||
                               (state == STABILIZE && stab_cnt == STAB_LAST));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_LOCK;
            stab_cnt      <= '0;
            sys_reset_n   <= 1'b0;
            locked_stable <= 1'b0;
        end else begin
            sys_reset_n   <= run_next;
            locked_stable <= run_next;
            case (state)
                WAIT_LOCK: begin
                    stab_cnt <= '0;
                    if (lk_s) begin
                        state <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state    <= RUN;
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state <= LOST;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

`ifdef PLL_CLOCK_MANAGER_LOSS_COUNT_EN
    logic [7:0] lost_cnt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lost_cnt <= 8'd0;
        end else if (state == RUN && !lk_s && lost_cnt != 8'hFF) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end

    assign lock_lost_count = lost_cnt;
`else
    assign lock_lost_count = 8'd0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] shadow;
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] d_last;
        logic                 tick_q;

        // A programmed divider of 0 behaves as 1.
        assign d_last = (shadow == '0) ? '0 : shadow - DIV_WIDTH'(1);

        always_ff @(posedge clock_in or negedge reset_n) begin
            if (!reset_n) begin
                shadow <= DIV_WIDTH'(DIV_RESET);
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (div_load[i]) begin
                shadow <= div_value[i*DIV_WIDTH +: DIV_WIDTH];
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (!run_next) begin
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (!ch_enable[i]) begin
                tick_q <= 1'b0;
            end else if (cnt == d_last) begin
                cnt    <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt    <= cnt + DIV_WIDTH'(1);
                tick_q <= 1'b0;
            end
        end

        assign tick[i] = tick_q;
    end

endmodule

// File: tb/tb_pll_clock_manager.sv
// tb/tb_pll_clock_manager.sv - directed self-checking bench for pll_clock_manager
module tb_pll_clock_manager;

    logic        clock_in;
    logic        reset_n;
    logic        pll_locked;
    logic [63:0] div_value;
    logic [3:0]  div_load;
    logic [3:0]  ch_enable;
    logic [3:0]  tick;
    logic        sys_reset_n;
    logic        locked_stable;
    logic [7:0]  lock_lost_count;

    int total = 0;
    int bad   = 0;
    int n;
    int m;
    logic [7:0] exp_loss;

    pll_clock_manager #(
        .NUM_CH(4),
        .DIV_WIDTH(16),
        .DIV_RESET(1),
        .LOCK_STABLE_CYCLES(16),
        .SYNC_STAGES(2)
    ) dut (
        .clock_in(clock_in),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .div_value(div_value),
        .div_load(div_load),
        .ch_enable(ch_enable),
        .tick(tick),
        .sys_reset_n(sys_reset_n),
        .locked_stable(locked_stable),
        .lock_lost_count(lock_lost_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic wait_run(input int start, output int cnt);
        cnt = start;
        while (!sys_reset_n && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_tick1(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tick[1] && cnt < 50);
    endtask

    initial begin
`ifdef PLL_CLOCK_MANAGER_LOSS_COUNT_EN
        exp_loss = 8'd1;
`else
        exp_loss = 8'd0;
`endif
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        div_value  = '0;
        div_load   = 4'b0000;
        ch_enable  = 4'hF;
        repeat (3) step();
        check("rst_sysrst", sys_reset_n, 0);
        check("rst_stable", locked_stable, 0);
        check("rst_tick", tick, 0);
        check("rst_loss", lock_lost_count, 0);

        // Release latency: 2 sync + 16 stable + 1
        reset_n = 1'b1;
        wait_run(0, n);
        check("rel_lat", n, 19);
        check("rel_stable", locked_stable, 1);
        check("rel_tick_all", tick, 4'hF);
        check("rel_loss", lock_lost_count, 0);

        // Lock glitch restarts the stability window
        reset_n = 1'b0;
        #1;
        step();
        step();
        reset_n   = 1'b1;
        div_value = {16'd5, 16'd0, 16'd3, 16'd1};
        div_load  = 4'hF;
        step();
        div_load  = 4'b0000;
        repeat (9) step();
        check("glitch_pre", sys_reset_n, 0);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_run(11, n);
        check("glitch_lat", n, 30);
        check("glitch_loss", lock_lost_count, 0);

        // Divider pattern per RUN cycle: d = 1, 3, 1(0), 5
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("div_c%0d", c), tick,
                  {(c % 5 == 0), 1'b1, (c % 3 == 0), 1'b1});
            step();
        end

        // Load ch1=4 on the edge where it would wrap (RUN cycle 12)
        div_value = {16'd5, 16'd0, 16'd4, 16'd1};
        div_load  = 4'b0010;
        step();
        div_load  = 4'b0000;
        check("load_wrap", tick[1], 0);
        wait_tick1(n);
        check("load_period", n, 4);

        // Pause ch1 for two cycles mid-count
        step();
        step();
        ch_enable = 4'b1101;
        step();
        step();
        ch_enable = 4'hF;
        wait_tick1(m);
        check("pause_gap", 4 + m, 6);

        // Lock loss in RUN for 3 cycles
        pll_locked = 1'b0;
        step();
        step();
        check("loss_hold", sys_reset_n, 1);
        step();
        pll_locked = 1'b1;
        check("loss_sysrst", sys_reset_n, 0);
        check("loss_stable", locked_stable, 0);
        check("loss_tick", tick, 0);
        check("loss_count", lock_lost_count, exp_loss);
        wait_run(0, n);
        check("relock_lat", n, 19);
        check("relock_c1", tick, 4'b0101);
        repeat (3) step();
        check("relock_c4", tick, 4'b0111);
        step();
        check("relock_c5", tick, 4'b1101);
        check("relock_loss", lock_lost_count, exp_loss);

        // Asynchronous reset mid-RUN
        reset_n = 1'b0;
        #1;
        check("arst_sysrst", sys_reset_n, 0);
        check("arst_stable", locked_stable, 0);
        check("arst_tick", tick, 0);
        check("arst_loss", lock_lost_count, 0);
        step();
        reset_n = 1'b1;
        wait_run(0, n);
        check("arst_lat", n, 19);
        check("arst_shadow", tick, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
